ip_msxbus_master: RTL and testbench
===================================

IP_MSXBUS_MASTER -- requirements
Module: ip_msxbus_master

Interface
REQ-001 SHALL have parameters: T_SETUP, 2, cycles of address/select setup before strobe; T_STROBE, 4, minimum cycles of n_rd/n_wr low; T_HOLD, 1, cycles of address/select hold after strobe release.
REQ-002 SHALL have ports: clk  in  1  single system clock; all logic on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 bus_address  in  16  request address. bus_write_data  in  8  write data.
REQ-005 bus_read / bus_write  in  1 each  request strobes, sampled only while bus_ready=1.
REQ-006 bus_io / bus_memory  in  1 each  request space select.
REQ-007 bus_ready  out  1  high only in IDLE. bus_read_data  out  8  latched read data. bus_read_valid  out  1  one-cycle read-complete pulse. bus_timeout  out  1  one-cycle abort pulse.
REQ-008 adr  out  16. o_data  out  8. data_oe  out  1  high while driving write data. i_data  in  8.
REQ-009 n_sltsl, n_mereq, n_ioreq, n_rd, n_wr  out  1 each  active-low. n_wait  in  1  active-low, asynchronous.

Function
REQ-010 SHALL accept a request on a clk edge where bus_ready=1, exactly one of bus_read/bus_write is 1, and exactly one of bus_io/bus_memory is 1; any other combination SHALL be ignored with no bus cycle.
REQ-011 On acceptance SHALL latch address, write data, direction and space, and enter SETUP.
REQ-012 States: IDLE -> SETUP (T_SETUP cycles) -> STROBE (>= T_STROBE cycles) -> HOLD (T_HOLD cycles) -> IDLE.
REQ-013 SETUP, STROBE, HOLD: adr = latched address; memory: n_sltsl=n_mereq=0; io: n_ioreq=0, n_sltsl=n_mereq=1.
REQ-014 STROBE: n_rd=0 (read) or n_wr=0 (write); both high in all other states.
REQ-015 Write: data_oe=1 and o_data=latched data throughout SETUP, STROBE, HOLD; data_oe=0 otherwise.
REQ-016 n_wait SHALL pass a 2-flop synchronizer; STROBE SHALL exit only when its cycle counter has expired and the synchronized n_wait=1.
REQ-017 Read: on the STROBE->HOLD edge SHALL latch i_data into bus_read_data and pulse bus_read_valid for exactly that following cycle; bus_read_data SHALL hold until next read completes.
REQ-018 Accept-to-bus_ready latency with n_wait high SHALL be T_SETUP+T_STROBE+T_HOLD cycles; back-to-back requests SHALL have one IDLE cycle between cycles.
REQ-019 Requests while bus_ready=0 SHALL be dropped, not queued.

Reset
REQ-020 reset=1 SHALL immediately force IDLE, all active-low outputs 1, adr=0, o_data=0, data_oe=0, bus_read_data=0, bus_read_valid=0, bus_timeout=0, bus_ready=1, synchronizer=11.
REQ-021 Reset during any state SHALL abort the cycle with no bus_read_valid pulse.

Configuration
REQ-022 With MSXBUS_WAIT_TIMEOUT_EN defined, an 8-bit counter SHALL count STROBE cycles with n_wait held low; at 255 SHALL exit to HOLD, pulse bus_timeout one cycle, suppress bus_read_valid and leave bus_read_data unchanged.
REQ-023 Without MSXBUS_WAIT_TIMEOUT_EN, STROBE SHALL wait indefinitely and bus_timeout SHALL be constant 0.

Verification
REQ-024 Memory read 0x4000, i_data=0xA5, n_wait=1 -> n_sltsl/n_mereq low 2 cycles before n_rd, n_rd low 4 cycles, bus_read_data=0xA5, one bus_read_valid pulse, bus_ready high 7 cycles after accept.
REQ-025 IO write adr 0x0098 data 0x3C -> n_ioreq low, n_sltsl/n_mereq high, n_wr low 4 cycles, data_oe=1, o_data=0x3C for 7 cycles.
REQ-026 Memory read with n_wait low 10 cycles from STROBE start -> n_rd low until 2 cycles after n_wait release; data latched once.
REQ-027 bus_read and bus_write both 1, or bus_io and bus_memory both 1 -> no strobe, bus_ready stays 1.
REQ-028 reset pulsed mid-STROBE of a write -> n_wr, n_mereq, n_sltsl high and data_oe=0 same cycle; no bus_read_valid.
REQ-029 With MSXBUS_WAIT_TIMEOUT_EN, n_wait held low permanently -> bus_timeout pulse after 255 wait cycles, bus_read_valid never pulses, return to IDLE.

Source files
------------

// File: rtl/ip_msxbus_master.sv
// MSX slot bus master: converts one-cycle host requests into SETUP/STROBE/HOLD bus cycles.
// Define MSXBUS_WAIT_TIMEOUT_EN to abort strobes stretched by n_wait for 255 cycles.
module ip_msxbus_master #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_address,
  input  logic [7:0]  bus_write_data,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic        bus_io,
  input  logic        bus_memory,
  output logic        bus_ready,
  output logic [7:0]  bus_read_data,
  output logic        bus_read_valid,
  output logic        bus_timeout,
  output logic [15:0] adr,
  output logic [7:0]  o_data,
  output logic        data_oe,
  input  logic [7:0]  i_data,
  output logic        n_sltsl,
  output logic        n_mereq,
  output logic        n_ioreq,
  output logic        n_rd,
  output logic        n_wr,
  input  logic        n_wait
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(T_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic             is_mem_q, is_mem_d;
  logic [1:0]       wait_sync_q, wait_sync_d;
  logic [15:0]      adr_q, adr_d;
  logic [7:0]       o_data_q, o_data_d;
  logic             data_oe_q, data_oe_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             bus_ready_q, bus_ready_d;
  logic             n_sltsl_q, n_sltsl_d;
  logic             n_mereq_q, n_mereq_d;
  logic             n_ioreq_q, n_ioreq_d;
  logic             n_rd_q, n_rd_d;
  logic             n_wr_q, n_wr_d;
  logic             wait_s;
  logic             req_ok;
  logic             active;
  logic             strobe;
`ifdef MSXBUS_WAIT_TIMEOUT_EN
  logic [7:0]       wto_cnt_q, wto_cnt_d;
  logic             bus_timeout_q, bus_timeout_d;
`endif

  always_comb begin
    wait_s      = wait_sync_q[1];
    req_ok      = bus_ready_q && (bus_read ^ bus_write) && (bus_io ^ bus_memory);
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    is_mem_d    = is_mem_q;
    adr_d       = adr_q;
    o_data_d    = o_data_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    wait_sync_d = {wait_sync_q[0], n_wait};
`ifdef MSXBUS_WAIT_TIMEOUT_EN
    wto_cnt_d     = wto_cnt_q;
    bus_timeout_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          state_d  = ST_SETUP;
          cnt_d    = SETUP_LD;
          is_wr_d  = bus_write;
          is_mem_d = bus_memory;
          adr_d    = bus_address;
          o_data_d = bus_write_data;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
`ifdef MSXBUS_WAIT_TIMEOUT_EN
          wto_cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        // Leave only once the minimum width is met and the peripheral has released n_wait.
        if (cnt_q == '0 && wait_s) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          if (!is_wr_q) begin
            rdata_d  = i_data;
            rvalid_d = 1'b1;
          end
        end else begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end
`ifdef MSXBUS_WAIT_TIMEOUT_EN
          if (!wait_s) begin
            if (wto_cnt_q == 8'd254) begin
              state_d       = ST_HOLD;
              cnt_d         = HOLD_LD;
              bus_timeout_d = 1'b1;
            end else begin
              wto_cnt_d = wto_cnt_q + 8'd1;
            end
          end
`endif
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus pins are registered from the next state so they change on the same edge as the FSM.
    active      = (state_d != ST_IDLE);
    strobe      = (state_d == ST_STROBE);
    bus_ready_d = !active;
    n_sltsl_d   = !(active && is_mem_d);
    n_mereq_d   = !(active && is_mem_d);
    n_ioreq_d   = !(active && !is_mem_d);
    n_rd_d      = !(strobe && !is_wr_d);
    n_wr_d      = !(strobe && is_wr_d);
    data_oe_d   = active && is_wr_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      is_mem_q    <= 1'b0;
      wait_sync_q <= 2'b11;
      adr_q       <= '0;
      o_data_q    <= '0;
      data_oe_q   <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      bus_ready_q <= 1'b1;
      n_sltsl_q   <= 1'b1;
      n_mereq_q   <= 1'b1;
      n_ioreq_q   <= 1'b1;
      n_rd_q      <= 1'b1;
      n_wr_q      <= 1'b1;
`ifdef MSXBUS_WAIT_TIMEOUT_EN
      wto_cnt_q     <= '0;
      bus_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      is_mem_q    <= is_mem_d;
      wait_sync_q <= wait_sync_d;
      adr_q       <= adr_d;
      o_data_q    <= o_data_d;
      data_oe_q   <= data_oe_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      bus_ready_q <= bus_ready_d;
      n_sltsl_q   <= n_sltsl_d;
      n_mereq_q   <= n_mereq_d;
      n_ioreq_q   <= n_ioreq_d;
      n_rd_q      <= n_rd_d;
      n_wr_q      <= n_wr_d;
`ifdef MSXBUS_WAIT_TIMEOUT_EN
      wto_cnt_q     <= wto_cnt_d;
      bus_timeout_q <= bus_timeout_d;
`endif
    end
  end

  assign bus_ready      = bus_ready_q;
  assign bus_read_data  = rdata_q;
  assign bus_read_valid = rvalid_q;
  assign adr            = adr_q;
  assign o_data         = o_data_q;
  assign data_oe        = data_oe_q;
  assign n_sltsl        = n_sltsl_q;
  assign n_mereq        = n_mereq_q;
  assign n_ioreq        = n_ioreq_q;
  assign n_rd           = n_rd_q;
  assign n_wr           = n_wr_q;
`ifdef MSXBUS_WAIT_TIMEOUT_EN
  assign bus_timeout    = bus_timeout_q;
`else
  assign bus_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_ip_msxbus_master.sv
// Bench for ip_msxbus_master: cycle-timing model of the bus protocol plus directed scenarios.
module tb_ip_msxbus_master;

  localparam int T_SETUP  = 2;
  localparam int T_STROBE = 4;
  localparam int T_HOLD   = 1;

  logic        clk;
  logic        reset;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_read, bus_write, bus_io, bus_memory;
  logic        bus_ready;
  logic [7:0]  bus_read_data;
  logic        bus_read_valid, bus_timeout;
  logic [15:0] adr;
  logic [7:0]  o_data;
  logic        data_oe;
  logic [7:0]  i_data;
  logic        n_sltsl, n_mereq, n_ioreq, n_rd, n_wr;
  logic        n_wait;

  ip_msxbus_master #(.T_SETUP(T_SETUP), .T_STROBE(T_STROBE), .T_HOLD(T_HOLD)) dut (
    .clk(clk), .reset(reset),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_read(bus_read), .bus_write(bus_write), .bus_io(bus_io), .bus_memory(bus_memory),
    .bus_ready(bus_ready), .bus_read_data(bus_read_data),
    .bus_read_valid(bus_read_valid), .bus_timeout(bus_timeout),
    .adr(adr), .o_data(o_data), .data_oe(data_oe), .i_data(i_data),
    .n_sltsl(n_sltsl), .n_mereq(n_mereq), .n_ioreq(n_ioreq), .n_rd(n_rd), .n_wr(n_wr),
    .n_wait(n_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  // Model: a transaction is described by cycles elapsed since acceptance (m_k)
  // and the elapsed count at which the strobe ended (m_se, 0 while still strobing).
  logic        m_busy, m_wr, m_mem, m_rvalid, m_tout, m_w1, m_w2;
  logic [15:0] m_adr;
  logic [7:0]  m_wd, m_rdata;
  int          m_k, m_se, m_wl;
  logic        m_strobe;

  assign m_strobe = m_busy && (m_k >= T_SETUP) && (m_se == 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_wr <= 1'b0; m_mem <= 1'b0; m_k <= 0; m_se <= 0; m_wl <= 0;
      m_adr <= '0; m_wd <= '0; m_rdata <= '0; m_rvalid <= 1'b0; m_tout <= 1'b0;
      m_w1 <= 1'b1; m_w2 <= 1'b1;
    end else begin
      m_w1 <= n_wait;
      m_w2 <= m_w1;
      m_rvalid <= 1'b0;
      m_tout <= 1'b0;
      if (!m_busy) begin
        if ((bus_read ^ bus_write) && (bus_io ^ bus_memory)) begin
          m_busy <= 1'b1; m_k <= 0; m_se <= 0; m_wl <= 0;
          m_wr <= bus_write; m_mem <= bus_memory; m_adr <= bus_address; m_wd <= bus_write_data;
        end
      end else begin
        m_k <= m_k + 1;
        if (m_strobe) begin
          if ((m_k + 1 - T_SETUP >= T_STROBE) && m_w2) begin
            m_se <= m_k + 1;
            if (!m_wr) begin
              m_rdata <= i_data;
              m_rvalid <= 1'b1;
            end
          end
`ifdef MSXBUS_WAIT_TIMEOUT_EN
          else if (!m_w2) begin
            if (m_wl + 1 == 255) begin
              m_se <= m_k + 1;
              m_tout <= 1'b1;
            end
            m_wl <= m_wl + 1;
          end
`endif
        end else if (m_se != 0 && m_k + 1 >= m_se + T_HOLD) begin
          m_busy <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk1("bus_ready", bus_ready, !m_busy);
      chk1("n_sltsl", n_sltsl, !(m_busy && m_mem));
      chk1("n_mereq", n_mereq, !(m_busy && m_mem));
      chk1("n_ioreq", n_ioreq, !(m_busy && !m_mem));
      chk1("n_rd", n_rd, !(m_strobe && !m_wr));
      chk1("n_wr", n_wr, !(m_strobe && m_wr));
      chk1("data_oe", data_oe, m_busy && m_wr);
      chk1("bus_read_valid", bus_read_valid, m_rvalid);
      chk1("bus_timeout", bus_timeout, m_tout);
      chk("bus_read_data", 32'(bus_read_data), 32'(m_rdata));
      if (m_busy) chk("adr", 32'(adr), 32'(m_adr));
      if (m_busy && m_wr) chk("o_data", 32'(o_data), 32'(m_wd));
    end
  end

  int r_lat, r_first_rd, r_mereq_lo, r_sltsl_lo, r_io_lo, r_rd_lo, r_wr_lo, r_oe, r_rv, r_to, r_odata_bad;

  task automatic clear_req();
    bus_read = 1'b0; bus_write = 1'b0; bus_io = 1'b0; bus_memory = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus_ready && !m_busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_bound", 32'(n < 600), 32'(1));
  endtask

  // Negedge i is the one after the (acceptance + i)th posedge.
  task automatic run_txn(input logic rd, input logic mem, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] di, input int wlo_from, input int wlo_to,
                         input int inj_at, input int budget);
    r_lat = -1; r_first_rd = -1; r_mereq_lo = 0; r_sltsl_lo = 0; r_io_lo = 0; r_rd_lo = 0;
    r_wr_lo = 0; r_oe = 0; r_rv = 0; r_to = 0; r_odata_bad = 0;
    @(negedge clk);
    bus_address = a; bus_write_data = d; i_data = di;
    bus_read = rd; bus_write = !rd; bus_memory = mem; bus_io = !mem;
    for (int i = 0; i < budget && r_lat < 0; i++) begin
      @(negedge clk);
      if (i == 0) clear_req();
      if (i == wlo_from) n_wait = 1'b0;
      if (i == wlo_to) n_wait = 1'b1;
      if (i == inj_at) begin bus_write = 1'b1; bus_io = 1'b1; bus_address = 16'hBEEF; end
      if (i == inj_at + 1) clear_req();
      if (!n_mereq) r_mereq_lo++;
      if (!n_sltsl) r_sltsl_lo++;
      if (!n_ioreq) r_io_lo++;
      if (!n_rd) r_rd_lo++;
      if (!n_rd && r_first_rd < 0) r_first_rd = i;
      if (!n_wr) r_wr_lo++;
      if (data_oe) r_oe++;
      if (data_oe && o_data !== d) r_odata_bad++;
      if (bus_read_valid) r_rv++;
      if (bus_timeout) r_to++;
      if (bus_ready) r_lat = i;
    end
  endtask

  task automatic bad_req(input logic rd, input logic wr, input logic io, input logic mem);
    int busy_n, stb_n;
    busy_n = 0; stb_n = 0;
    @(negedge clk);
    bus_address = 16'hFFFF; bus_read = rd; bus_write = wr; bus_io = io; bus_memory = mem;
    @(negedge clk);
    clear_req();
    repeat (4) begin
      if (!bus_ready) busy_n++;
      if (!n_rd || !n_wr || !n_mereq || !n_ioreq || !n_sltsl) stb_n++;
      @(negedge clk);
    end
    chk("bad_req_busy", 32'(busy_n), 32'(0));
    chk("bad_req_strobe", 32'(stb_n), 32'(0));
  endtask

  task automatic reset_mid(input logic rd);
    int rv;
    @(negedge clk);
    bus_address = 16'h1234; bus_write_data = 8'hC3; i_data = 8'h77;
    bus_read = rd; bus_write = !rd; bus_memory = 1'b1; bus_io = 1'b0;
    @(negedge clk);
    clear_req();
    repeat (3) @(negedge clk);
    chk1("mid_strobe_active", rd ? n_rd : n_wr, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk1("rst_n_wr", n_wr, 1'b1);
    chk1("rst_n_rd", n_rd, 1'b1);
    chk1("rst_n_mereq", n_mereq, 1'b1);
    chk1("rst_n_sltsl", n_sltsl, 1'b1);
    chk1("rst_data_oe", data_oe, 1'b0);
    chk1("rst_bus_ready", bus_ready, 1'b1);
    chk("rst_adr", 32'(adr), 32'(0));
    @(negedge clk);
    #2 reset = 1'b0;
    rv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_read_valid) rv++;
    end
    chk("rst_no_rvalid", 32'(rv), 32'(0));
    chk("rst_rdata", 32'(bus_read_data), 32'(0));
  endtask

  initial begin
    int cnt;
    reset = 1'b1; n_wait = 1'b1; i_data = 8'h00;
    bus_address = '0; bus_write_data = '0;
    clear_req();
    #1;
    chk1("por_bus_ready", bus_ready, 1'b1);
    chk("por_n_pins", 32'({n_sltsl, n_mereq, n_ioreq, n_rd, n_wr}), 32'(5'b11111));
    chk("por_adr", 32'(adr), 32'(0));
    chk("por_o_data", 32'(o_data), 32'(0));
    chk1("por_data_oe", data_oe, 1'b0);
    chk("por_rdata", 32'(bus_read_data), 32'(0));
    chk1("por_rvalid", bus_read_valid, 1'b0);
    chk1("por_timeout", bus_timeout, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;

    // Memory read, no wait states.
    wait_idle();
    run_txn(1'b1, 1'b1, 16'h4000, 8'h00, 8'hA5, -1, -1, -1, 40);
    chk("mrd_latency", 32'(r_lat), 32'(7));
    chk("mrd_setup_before_rd", 32'(r_first_rd), 32'(2));
    chk("mrd_rd_low", 32'(r_rd_lo), 32'(4));
    chk("mrd_mereq_low", 32'(r_mereq_lo), 32'(7));
    chk("mrd_sltsl_low", 32'(r_sltsl_lo), 32'(7));
    chk("mrd_ioreq_low", 32'(r_io_lo), 32'(0));
    chk("mrd_rvalid", 32'(r_rv), 32'(1));
    chk("mrd_rdata", 32'(bus_read_data), 32'(8'hA5));

    // IO write.
    wait_idle();
    run_txn(1'b0, 1'b0, 16'h0098, 8'h3C, 8'h00, -1, -1, -1, 40);
    chk("iow_latency", 32'(r_lat), 32'(7));
    chk("iow_ioreq_low", 32'(r_io_lo), 32'(7));
    chk("iow_mereq_low", 32'(r_mereq_lo), 32'(0));
    chk("iow_sltsl_low", 32'(r_sltsl_lo), 32'(0));
    chk("iow_wr_low", 32'(r_wr_lo), 32'(4));
    chk("iow_rd_low", 32'(r_rd_lo), 32'(0));
    chk("iow_oe", 32'(r_oe), 32'(7));
    chk("iow_odata_bad", 32'(r_odata_bad), 32'(0));
    chk("iow_rdata_kept", 32'(bus_read_data), 32'(8'hA5));

    // Memory read stretched by n_wait for 10 strobe cycles.
    wait_idle();
    run_txn(1'b1, 1'b1, 16'h7FFE, 8'h00, 8'h96, 1, 11, -1, 60);
    chk("wait_latency", 32'(r_lat), 32'(15));
    chk("wait_rd_low", 32'(r_rd_lo), 32'(12));
    chk("wait_rvalid", 32'(r_rv), 32'(1));
    chk("wait_rdata", 32'(bus_read_data), 32'(8'h96));

    // Memory write with a request injected while busy.
    wait_idle();
    run_txn(1'b0, 1'b1, 16'h8001, 8'h5A, 8'h00, -1, -1, 3, 40);
    chk("drop_latency", 32'(r_lat), 32'(7));
    chk("drop_wr_low", 32'(r_wr_lo), 32'(4));
    chk("drop_ioreq_low", 32'(r_io_lo), 32'(0));
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_ready) cnt++;
    end
    chk("drop_ready_after", 32'(cnt), 32'(5));

    // Malformed requests.
    wait_idle();
    bad_req(1'b1, 1'b1, 1'b0, 1'b1);
    bad_req(1'b1, 1'b0, 1'b1, 1'b1);
    bad_req(1'b0, 1'b1, 1'b0, 1'b0);
    bad_req(1'b0, 1'b0, 1'b0, 1'b1);

    // Request held high: back-to-back cycles.
    wait_idle();
    @(negedge clk);
    bus_address = 16'h2000; i_data = 8'h11; bus_read = 1'b1; bus_memory = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_ready) cnt++;
    end
    clear_req();
    chk("b2b_ready_gaps", 32'(cnt), 32'(2));

    wait_idle();
    reset_mid(1'b0);
    wait_idle();
    reset_mid(1'b1);

`ifdef MSXBUS_WAIT_TIMEOUT_EN
    wait_idle();
    run_txn(1'b1, 1'b1, 16'h3000, 8'h00, 8'h5C, -1, -1, -1, 40);
    chk("pre_to_rdata", 32'(bus_read_data), 32'(8'h5C));
    wait_idle();
    run_txn(1'b1, 1'b1, 16'h4444, 8'h00, 8'hEE, 0, -1, -1, 400);
    n_wait = 1'b1;
    chk("to_latency", 32'(r_lat), 32'(258));
    chk("to_pulse", 32'(r_to), 32'(1));
    chk("to_no_rvalid", 32'(r_rv), 32'(0));
    chk("to_rdata_kept", 32'(bus_read_data), 32'(8'h5C));
`endif

    wait_idle();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
